// File: rtl/mul24_pkg.sv
// ============================================================================
// Module   : mul24_pkg
// Purpose  : Shared widths, iteration count and FSM encoding for mul24_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul24_pkg;

    localparam int MUL_W    = 24;
    localparam int PROD_W   = 2 * MUL_W;
    localparam int MUL_ITER = MUL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mul_state_e;

endpackage : mul24_pkg

`default_nettype wire

// File: rtl/mul24_step.sv
// ============================================================================
// Module   : mul24_step
// Purpose  : One combinational shift-add iteration: conditionally accumulate
//            the aligned multiplicand and advance it one bit position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul24_step
    import mul24_pkg::*;
#(
    parameter int PW = PROD_W
) (
    input  logic [PW-1:0] i_acc,
    input  logic [PW-1:0] i_mcand,
    input  logic          i_bit,
    output logic [PW-1:0] o_acc,
    output logic [PW-1:0] o_mcand
);

    always_comb begin
        o_acc   = i_bit ? (i_acc + i_mcand) : i_acc;
        o_mcand = {i_mcand[PW-2:0], 1'b0};
    end

endmodule : mul24_step

`default_nettype wire

// File: rtl/mul24_seq.sv
// ============================================================================
// Module   : mul24_seq
// Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle,
//            fixed 25-cycle latency. Define MUL24_SIGNED_EN to build in the
//            two's-complement (sign-magnitude) path honoured via signed_op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul24_seq
    import mul24_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    mul_state_e        state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [PW-1:0]     acc_q,     acc_d;
    logic [PW-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]  mplier_q,  mplier_d;
    logic [PW-1:0]     product_q, product_d;
    logic              done_q,    done_d;

    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic [PW-1:0]     w_result;
    logic [PW-1:0]     w_acc_nxt;
    logic [PW-1:0]     w_mcand_nxt;

`ifdef MUL24_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitudes stay WIDTH bits wide: the most negative operand maps onto
    // itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        w_a_mag = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
        w_b_mag = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
        w_result = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_comb begin
        neg_d = neg_q;
        if (state_q == IDLE && start) begin
            neg_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`else
    logic w_unused_signed_op;

    assign w_unused_signed_op = signed_op;

    always_comb begin
        w_a_mag  = a;
        w_b_mag  = b;
        w_result = acc_q;
    end
`endif

    mul24_step #(
        .PW (PW)
    ) u_step (
        .i_acc   (acc_q),
        .i_mcand (mcand_q),
        .i_bit   (mplier_q[0]),
        .o_acc   (w_acc_nxt),
        .o_mcand (w_mcand_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, w_a_mag};
                    mplier_d = w_b_mag;
                end
            end
            RUN: begin
                // Multiplier shifts right so its LSB is always the live bit.
                acc_d    = w_acc_nxt;
                mcand_d  = w_mcand_nxt;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                product_d = w_result;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule : mul24_seq

`default_nettype wire

// File: doc/mul24_seq.md
# mul24_seq

Iterative 24×24 shift-add multiplier for the 24-bit CPU datapath. It accepts two operands on a start strobe and returns a 48-bit product after a fixed 25-cycle latency. The product is held stable until the next operation. The held product feeds the ALU result select's multiply input, which routes both the 24-bit result and the full 48-bit multiply output. The control unit stalls on `busy` and resumes on the `done` pulse.

## Interface
- `WIDTH`, 24: operand width; the product is 2·WIDTH bits.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `start` in 1: request a multiply; honoured only in IDLE.
- `signed_op` in 1: 1 means operands are two's complement; 0 means unsigned.
- `a` in 24: multiplicand.
- `b` in 24: multiplier.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when `product` is updated.
- `product` out 48: registered result; holds its value until the next completion or reset.

## Operation
- States and transitions:
  - IDLE → RUN when `start` = 1.
  - RUN → FIN after 24 iterations.
  - FIN → IDLE unconditionally.
- Start (IDLE, `start` = 1, edge E0):
  - Latch `a`, `b` and `signed_op`.
  - When signed, latch magnitudes |a| and |b|, plus neg = a[23] ^ b[23].
  - Clear the 48-bit accumulator; iteration counter = 0.
  - Later changes on the inputs are ignored.
- RUN, one bit per edge, LSB first:
  - If the current multiplier bit = 1, add the multiplicand (shifted by the counter) to the accumulator.
  - Increment the counter; after count 23 is processed, go to FIN.
- FIN:
  - `product` ← neg ? −accumulator (48-bit two's complement) : accumulator.
  - `done` ← 1; state ← IDLE.
- Width rules:
  - Magnitudes are 24-bit unsigned; |−2²³| = 0x800000 fits.
  - The accumulator is 48 bits; no intermediate overflow is possible.
  - The result is exact for all operand pairs.
- Boundary conditions:
  - `start` while busy: ignored; no queueing, no effect on the current operation.
  - `start` during the cycle in which `done` is high: accepted, because the state is already IDLE.
  - Zero operands: still take the full latency; result 0 with no negative zero (−0 = 0).
  - Reset mid-operation: next edge forces IDLE, `busy` = 0, `done` = 0, `product` = 0; the partial result is discarded.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `product` 0x000000000000, counter 0.
- Start sampled at edge E0; RUN iterations occupy edges E1–E24; FIN at E24; E25 writes `product` and asserts `done`.
- `busy` is high from after E0 through the cycle following E24, and low after E25.
- `done` is high for exactly the one cycle after E25.
- Latency from start to result is 25 cycles.
- Back-to-back throughput is one result per 26 cycles.
- `product` changes only at the FIN edge or on reset.

## Configuration
- `MUL24_SIGNED_EN` defined:
  - Sign-magnitude conversion and final negation are built in; `signed_op` is honoured.
- `MUL24_SIGNED_EN` undefined:
  - `signed_op` is ignored and all operations are unsigned; the negation logic is absent.
  - Timing is unchanged.

## Structure
- Shared package `mul24_pkg`:
  - `MUL_W` = 24 and `PROD_W` = 48.
  - `MUL_ITER` = 24.
  - State enum: IDLE, RUN, FIN.
- Sub-module `mul24_step`: combinational single-iteration add-shift of the accumulator and multiplicand under the current multiplier bit.
- Top level holds the FSM, counter and registers.

## Test plan
- Reset, then `a` = 3, `b` = 5, unsigned, one-cycle `start` → `busy` for 25 cycles; `done` pulses once; `product` = 0x00000000000F.
- `a` = `b` = 0xFFFFFF:
  - unsigned → 0xFFFFFE000001;
  - signed → 0x000000000001.
- Signed, `a` = 0xFFFFFF, `b` = 0x000002 → 0xFFFFFFFFFFFE; same operands unsigned → 0x000001FFFFFE.
- Signed, `a` = `b` = 0x800000 → 0x400000000000. With the macro undefined, the same operands → 0x400000000000 (unsigned) and `signed_op` has no effect on 0xFFFFFF × 2, giving 0x000001FFFFFE.
- Start 7×9; pulse `start` with 2×2 at cycle 10; hold `start` high through the `done` cycle.
  - Result 0x3F; the mid-run start is ignored.
  - A new operation begins in the cycle after `done` and yields 4.
- Start 7×9; drive `rst_n` = 0 at cycle 12 for one edge → `busy` 0, `product` 0, no `done`. A following 1×1 → 1 after 25 cycles.
